// File: rtl/bcd_seg_formatter.sv
// rtl/bcd_seg_formatter.sv - sequential double-dabble BCD conversion to active-low 4-digit seven-segment bus
module bcd_seg_formatter #(
    parameter bit LZ_BLANK_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [13:0] value,
    input  logic        lz_blank,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [27:0] sev_seg_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lzb_q, lzb_d;
    logic        ovf_pend_q, ovf_pend_d;
    logic        overflow_q, overflow_d;
    logic        done_q, done_d;
    logic [27:0] sev_q, sev_d;
    logic [15:0] bcd_adj;
    logic [27:0] sev_enc;
    logic        unused_lz_default;

    assign unused_lz_default = LZ_BLANK_DEFAULT;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] n);
        dabble = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        bcd_adj = {dabble(bcd_q[15:12]), dabble(bcd_q[11:8]),
                   dabble(bcd_q[7:4]),   dabble(bcd_q[3:0])};
    end

    // A digit blanks only while every digit to its left is also zero.
    always_comb begin
        logic blank3, blank2, blank1;
        blank3  = lzb_q && (bcd_q[15:12] == 4'd0);
        blank2  = blank3 && (bcd_q[11:8] == 4'd0);
        blank1  = blank2 && (bcd_q[7:4] == 4'd0);
        sev_enc = {blank3 ? SEG_BLANK : seg_of(bcd_q[15:12]),
                   blank2 ? SEG_BLANK : seg_of(bcd_q[11:8]),
                   blank1 ? SEG_BLANK : seg_of(bcd_q[7:4]),
                   seg_of(bcd_q[3:0])};
        if (ovf_pend_q) begin
            sev_enc = {4{SEG_DASH}};
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        lzb_d      = lzb_q;
        ovf_pend_d = ovf_pend_q;
        overflow_d = overflow_q;
        sev_d      = sev_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d      = value;
                    lzb_d      = lz_blank;
                    ovf_pend_d = (value > 14'd9999);
                    bcd_d      = 16'd0;
                    cnt_d      = 4'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                sev_d      = sev_enc;
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bin_q      <= 14'd0;
            bcd_q      <= 16'd0;
            cnt_q      <= 4'd0;
            lzb_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            sev_q      <= 28'hFFFFFFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            lzb_q      <= lzb_d;
            ovf_pend_q <= ovf_pend_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            sev_q      <= sev_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign sev_seg_data = sev_q;

endmodule

// File: tb/tb_bcd_seg_formatter.sv
// tb/tb_bcd_seg_formatter.sv - randomized self-checking bench for bcd_seg_formatter
module tb_bcd_seg_formatter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value = 14'd0;
    logic        lz_blank = 1'b0;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [27:0] sev_seg_data;

    int checks = 0;
    int errors = 0;

    bcd_seg_formatter #(.LZ_BLANK_DEFAULT(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load         (load),
        .value        (value),
        .lz_blank     (lz_blank),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .sev_seg_data (sev_seg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_digit(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [27:0] ref_display(input int v, input bit lz);
        int          digits [4];
        bit          leading;
        logic [27:0] r;
        if (v > 9999) return {4{7'b0111111}};
        digits[3] = v / 1000;
        digits[2] = (v / 100) % 10;
        digits[1] = (v / 10) % 10;
        digits[0] = v % 10;
        leading = lz;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (leading && digits[i] == 0 && i != 0) begin
                r[i*7 +: 7] = 7'b1111111;
            end else begin
                leading = 1'b0;
                r[i*7 +: 7] = ref_digit(digits[i]);
            end
        end
        return r;
    endfunction

    task automatic run_conv(input int v, input bit lz, input string tag);
        int n;
        bit busy_gap;
        @(posedge clk); #1;
        value = v[13:0]; lz_blank = lz; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        value = 14'($urandom); lz_blank = 1'($urandom);
        chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        n = 0; busy_gap = 1'b0;
        while (!done && n < 40) begin
            if (!busy) busy_gap = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 32'd15);
        chk({tag, "_busy_gap"}, {31'd0, busy_gap}, 32'd0);
        chk({tag, "_seg"}, {4'd0, sev_seg_data}, {4'd0, ref_display(v, lz)});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, v > 9999});
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int  dones;
        bit  busy_bad;
        #12;
        chk("rst_seg", {4'd0, sev_seg_data}, 32'h0FFFFFFF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        run_conv(1234, 1'b0, "v1234");
        run_conv(0, 1'b1, "v0_lz");
        run_conv(7, 1'b0, "v7");
        run_conv(9999, 1'b0, "v9999");
        run_conv(10000, 1'b0, "v10000");
        run_conv(16383, 1'b1, "v16383");
        run_conv(305, 1'b1, "v305_lz");
        run_conv(5000, 1'b1, "v5000_lz");
        run_conv(9999, 1'b1, "v9999_ovf_clear");

        for (int i = 0; i < 40; i++) begin
            int rv;
            rv = (i % 4 == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
            run_conv(rv, 1'($urandom), $sformatf("rnd%0d", i));
        end

        // Loads during a conversion (and in the encode cycle) must be dropped.
        @(posedge clk); #1;
        value = 14'd42; lz_blank = 1'b1; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        dones = 0; busy_bad = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            value = 14'd99; lz_blank = 1'b0;
            load = (k == 3 || k == 15);
            @(posedge clk); #1;
            if (done) dones++;
            if (k <= 14 && !busy) busy_bad = 1'b1;
            if (k == 15) begin
                chk("ign_done_at15", {31'd0, done}, 32'd1);
                chk("ign_seg", {4'd0, sev_seg_data}, {4'd0, ref_display(42, 1'b1)});
            end
        end
        load = 1'b0;
        chk("ign_busy_continuous", {31'd0, busy_bad}, 32'd0);
        chk("ign_done_count", dones, 32'd1);
        chk("ign_idle_after", {31'd0, busy}, 32'd0);
        chk("ign_seg_hold", {4'd0, sev_seg_data}, {4'd0, ref_display(42, 1'b1)});

        // Reset in mid-conversion aborts with reset outputs and no done.
        run_conv(16383, 1'b0, "pre_rst");
        @(posedge clk); #1;
        value = 14'd1111; lz_blank = 1'b0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_seg", {4'd0, sev_seg_data}, 32'h0FFFFFFF);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 32'd0);
        run_conv(1234, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
